// File: rtl/wf_chirp_packer_if.sv
// wf_chirp_packer_if: AXI-Stream link carrying packed {Q, I} sample beats.
//   tdata  : beat payload, DATA_W bits
//   tvalid : beat present
//   tlast  : final beat of the packet
//   tkeep  : byte enables (all ones while tvalid)
//   tready : sink accepts the beat
// master: the packer side, slave: the waveform_stream side.
interface wf_chirp_packer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   tdata;
  logic                tvalid;
  logic                tlast;
  logic [DATA_W/8-1:0] tkeep;
  logic                tready;

  modport master (output tdata, tvalid, tlast, tkeep, input  tready);
  modport slave  (input  tdata, tvalid, tlast, tkeep, output tready);
endinterface

// File: rtl/wf_chirp_packer.sv
// wf_chirp_packer: on arm, requests a waveform_stream write, captures
// num_samples DDS I/Q samples from the next chirp and emits them as one
// AXI-Stream packet. A 16-entry FWFT FIFO absorbs tready stalls because
// the DDS cannot be held off.
//
// Ports:
//   clk_in1, reset        : clock, asynchronous active-high reset
//   arm, num_samples,
//   param_upper           : start request and packet parameters (latched on arm)
//   dds_i/q, dds_valid    : DDS sample stream
//   chirp_active/done     : chirp window / end-of-chirp pulse
//   init_wf_write,
//   wf_write_ready        : write-open handshake with waveform_stream
//   waveform_parameters   : {param_upper, zero-extended num_samples}
//   wfin_axis             : AXI-Stream master, tdata = {Q, I}
//   busy, done            : not IDLE / one-cycle packet-complete pulse
//   overflow, short_chirp : sticky status, cleared on accepted arm
//
// Build option: define WF_PACKER_PAD_EN to zero-pad a packet whose chirp
// ends early up to num_samples; otherwise the packet is cut short.
module wf_chirp_packer #(
  parameter int FIFO_AW  = 4,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk_in1,
  input  logic                reset,
  input  logic                arm,
  input  logic [15:0]         num_samples,
  input  logic [95:0]         param_upper,
  input  logic [SAMPLE_W-1:0] dds_i,
  input  logic [SAMPLE_W-1:0] dds_q,
  input  logic                dds_valid,
  input  logic                chirp_active,
  input  logic                chirp_done,
  output logic                init_wf_write,
  input  logic                wf_write_ready,
  output logic [127:0]        waveform_parameters,
  wf_chirp_packer_if.master   wfin_axis,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                short_chirp
);
  localparam int DW    = 2 * SAMPLE_W;
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAP   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  state, state_d;
  logic [15:0] cnt_q, num_q, cnt_inc;

  // FIFO: output register holds the head, mem holds the rest; together at
  // most DEPTH entries, so mem never holds more than DEPTH-1.
  logic [DW:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   mem_cnt;
  logic               out_vld, out_last;
  logic [DW-1:0]      out_data;

  logic          pop, full, space_ok, load_out, mem_rd, mem_wr;
  logic          push_req, push_ok, push_last, tag_mem;
  logic [DW-1:0] push_dat;
  logic          arm_ok, cap_live, early, hit_cnt, short_evt, ovf_evt;

  assign cnt_inc  = cnt_q + 16'd1;
  assign arm_ok   = (state == S_IDLE) & arm & (num_samples != 16'd0);
  assign pop      = out_vld & wfin_axis.tready;
  assign full     = out_vld & (mem_cnt == (FIFO_AW+1)'(DEPTH - 1));
  // A pop in the same cycle frees a slot, so a push into a full FIFO holds.
  assign space_ok = !full | pop;
  assign load_out = !out_vld | pop;
  assign mem_rd   = load_out & (mem_cnt != '0);
  assign push_ok  = push_req & space_ok;
  // Push goes straight to the output register when the FIFO drains empty.
  assign mem_wr   = push_ok & !(load_out & (mem_cnt == '0));
  assign hit_cnt  = dds_valid & space_ok & (cnt_inc == num_q);

`ifdef WF_PACKER_PAD_EN
  logic pad_q;
  assign cap_live = (state == S_CAP) & !pad_q;
`else
  logic newest_in_mem;
  // The newest entry stays editable only while it sits in mem and is not
  // being moved into the (already visible) output register this cycle.
  assign newest_in_mem = (mem_cnt > (FIFO_AW+1)'(1)) |
                         ((mem_cnt == (FIFO_AW+1)'(1)) & !load_out);
  assign cap_live = (state == S_CAP);
`endif

  assign early     = cap_live & (chirp_done | !chirp_active);
  assign short_evt = early & !hit_cnt;
  assign ovf_evt   = cap_live & dds_valid & !space_ok;

  always_comb begin
    state_d   = state;
    push_req  = 1'b0;
    push_dat  = '0;
    push_last = 1'b0;
    tag_mem   = 1'b0;
    case (state)
      S_IDLE:  if (arm_ok) state_d = S_REQ;
      S_REQ:   if (wf_write_ready) state_d = S_WAIT;
      S_WAIT:  if (chirp_active & dds_valid) begin
        // FIFO is empty here, so sample 0 is always accepted.
        push_req  = 1'b1;
        push_dat  = {dds_q, dds_i};
        push_last = (num_q == 16'd1);
        state_d   = (num_q == 16'd1) ? S_DRAIN : S_CAP;
      end
      S_CAP: begin
`ifdef WF_PACKER_PAD_EN
        if (pad_q) begin
          push_req  = 1'b1;
          push_last = (cnt_inc == num_q);
          if (space_ok && push_last) state_d = S_DRAIN;
        end else if (dds_valid) begin
          push_req  = 1'b1;
          push_dat  = {dds_q, dds_i};
          push_last = (cnt_inc == num_q);
          if (hit_cnt) state_d = S_DRAIN;
        end
`else
        if (dds_valid) begin
          push_req  = 1'b1;
          push_dat  = {dds_q, dds_i};
          push_last = (cnt_inc == num_q) | early;
        end
        if (hit_cnt) state_d = S_DRAIN;
        else if (early) begin
          state_d = S_DRAIN;
          // No sample landed this cycle: mark the newest queued entry, or
          // close the packet with a zero beat if that entry is already
          // committed to the output register (its tlast must not change).
          if (!(dds_valid && space_ok)) begin
            if (newest_in_mem) tag_mem = 1'b1;
            else begin
              push_req  = 1'b1;
              push_last = 1'b1;
            end
          end
        end
`endif
      end
      S_DRAIN: if (pop & out_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      cnt_q               <= '0;
      num_q               <= '0;
      waveform_parameters <= '0;
      overflow            <= 1'b0;
      short_chirp         <= 1'b0;
      done                <= 1'b0;
    end else begin
      state <= state_d;
      done  <= (state == S_DRAIN) & pop & out_last;
      if (arm_ok) begin
        num_q               <= num_samples;
        waveform_parameters <= {param_upper, 16'h0000, num_samples};
        cnt_q               <= '0;
        overflow            <= 1'b0;
        short_chirp         <= 1'b0;
      end else begin
        if (push_ok)   cnt_q       <= cnt_inc;
        if (ovf_evt)   overflow    <= 1'b1;
        if (short_evt) short_chirp <= 1'b1;
      end
    end
  end

`ifdef WF_PACKER_PAD_EN
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset)          pad_q <= 1'b0;
    else if (arm_ok)    pad_q <= 1'b0;
    else if (short_evt) pad_q <= 1'b1;
  end
`endif

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (mem_rd) rd_ptr <= rd_ptr + FIFO_AW'(1);
      mem_cnt <= mem_cnt + (FIFO_AW+1)'(mem_wr) - (FIFO_AW+1)'(mem_rd);
      if (load_out) begin
        if (mem_rd) begin
          out_data <= mem[rd_ptr][DW-1:0];
          out_last <= mem[rd_ptr][DW];
          out_vld  <= 1'b1;
        end else if (push_ok) begin
          out_data <= push_dat;
          out_last <= push_last;
          out_vld  <= 1'b1;
        end else begin
          out_vld  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in1) begin
    if (mem_wr)  mem[wr_ptr] <= {push_last, push_dat};
    if (tag_mem) mem[wr_ptr - FIFO_AW'(1)][DW] <= 1'b1;
  end

  assign wfin_axis.tdata  = out_data;
  assign wfin_axis.tvalid = out_vld;
  assign wfin_axis.tlast  = out_vld & out_last;
  assign wfin_axis.tkeep  = {(DW/8){out_vld}};
  assign busy             = (state != S_IDLE);
  assign init_wf_write    = (state == S_REQ);
endmodule

// File: tb/tb_wf_chirp_packer.sv
module tb_wf_chirp_packer;
  logic         clk_in1 = 1'b0;
  logic         reset = 1'b1;
  logic         arm = 1'b0;
  logic [15:0]  num_samples = '0;
  logic [95:0]  param_upper = '0;
  logic [15:0]  dds_i = '0, dds_q = '0;
  logic         dds_valid = 1'b0, chirp_active = 1'b0, chirp_done = 1'b0;
  logic         init_wf_write, wf_write_ready = 1'b0;
  logic [127:0] waveform_parameters;
  logic         busy, done, overflow, short_chirp;

  wf_chirp_packer_if #(.DATA_W(32)) wfin_axis();

  wf_chirp_packer #(.FIFO_AW(4), .SAMPLE_W(16)) dut (
    .clk_in1(clk_in1), .reset(reset), .arm(arm), .num_samples(num_samples),
    .param_upper(param_upper), .dds_i(dds_i), .dds_q(dds_q),
    .dds_valid(dds_valid), .chirp_active(chirp_active), .chirp_done(chirp_done),
    .init_wf_write(init_wf_write), .wf_write_ready(wf_write_ready),
    .waveform_parameters(waveform_parameters), .wfin_axis(wfin_axis),
    .busy(busy), .done(done), .overflow(overflow), .short_chirp(short_chirp)
  );

  always #5 clk_in1 = ~clk_in1;

  int checks = 0, errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int stab_err = 0;
  logic [31:0]  beats[$];
  bit           lasts[$];
  int           hs_cyc[$];
  int           done_cyc[$];
  logic [127:0] last_params;

  always @(posedge clk_in1) cyc <= cyc + 1;

  // tready: always high, or high one cycle in four
  initial begin
    wfin_axis.tready = 1'b1;
    forever begin
      @(posedge clk_in1); #1;
      wfin_axis.tready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
    end
  end

  // beat collector and AXIS stability watcher
  initial begin
    logic ps, pl;
    logic [31:0] pd;
    ps = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk_in1);
      if (reset) ps = 1'b0;
      else begin
        if (ps && (wfin_axis.tvalid !== 1'b1 || wfin_axis.tdata !== pd ||
                   wfin_axis.tlast !== pl)) stab_err++;
        if (wfin_axis.tvalid && wfin_axis.tready) begin
          beats.push_back(wfin_axis.tdata);
          lasts.push_back(wfin_axis.tlast);
          hs_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        ps = wfin_axis.tvalid && !wfin_axis.tready;
        pd = wfin_axis.tdata;
        pl = wfin_axis.tlast;
      end
    end
  end

  function automatic logic [31:0] samp(int k);
    return {16'(32'hC000 + k), 16'(32'h1000 + k)};
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk_in1); #1; end
  endtask

  task automatic clear_mon();
    beats.delete(); lasts.delete(); hs_cyc.delete(); done_cyc.delete();
    stab_err = 0;
  endtask

  task automatic arm_req(input logic [15:0] n, input logic [95:0] up);
    num_samples = n; param_upper = up; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic grant();
    wf_write_ready = 1'b1; tick(); wf_write_ready = 1'b0;
  endtask

  task automatic drive(int k);
    chirp_active = 1'b1; dds_valid = 1'b1;
    dds_i = 16'(32'h1000 + k); dds_q = 16'(32'hC000 + k);
  endtask

  task automatic stop_dds();
    dds_valid = 1'b0; chirp_active = 1'b0; chirp_done = 1'b0;
  endtask

  task automatic wait_done(int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in1);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    tick();
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({wfin_axis.tvalid, wfin_axis.tlast, wfin_axis.tkeep, init_wf_write, busy,
         done, overflow, short_chirp} !== 11'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {wfin_axis.tvalid, wfin_axis.tlast,
               wfin_axis.tkeep, init_wf_write, busy, done, overflow, short_chirp});
    end
    checks++;
    if (wfin_axis.tdata !== 32'd0) begin
      errors++; $display("FAIL reset_tdata: got %h want 0", wfin_axis.tdata);
    end
    checks++;
    if (waveform_parameters !== 128'd0) begin
      errors++; $display("FAIL reset_params: got %h want 0", waveform_parameters);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_nominal();
    bit ok; int bad, lbad, first_cyc;
    logic [95:0] up;
    up = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
    clear_mon(); rdy_mode = 0;
    checks++;
    if (init_wf_write !== 1'b0) begin
      errors++; $display("FAIL nom_init_idle: got %b want 0", init_wf_write);
    end
    arm_req(16'd128, up);
    checks++;
    if (init_wf_write !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL nom_init_rise: got %b%b want 11", init_wf_write, busy);
    end
    checks++;
    if (waveform_parameters !== {up, 32'h80}) begin
      errors++; $display("FAIL nom_params: got %h want %h", waveform_parameters, {up, 32'h80});
    end
    tick(2);
    grant();
    checks++;
    if (init_wf_write !== 1'b0) begin
      errors++; $display("FAIL nom_init_fall: got %b want 0", init_wf_write);
    end
    first_cyc = cyc;
    for (int k = 0; k < 128; k++) begin drive(k); tick(); end
    stop_dds();
    wait_done(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nom_done: got timeout want done"); end
    checks++;
    if (beats.size() !== 128) begin
      errors++; $display("FAIL nom_len: got %0d want 128", beats.size());
    end else begin
      bad = 0; lbad = 0;
      for (int i = 0; i < 128; i++) begin
        if (beats[i] !== samp(i)) bad++;
        if (lasts[i] !== (i == 127)) lbad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL nom_data: got %0d bad beats want 0", bad); end
      checks++;
      if (lbad != 0) begin errors++; $display("FAIL nom_tlast: got %0d bad tlast want 0", lbad); end
      checks++;
      if (hs_cyc[0] != first_cyc + 1) begin
        errors++; $display("FAIL nom_latency: got %0d want %0d", hs_cyc[0], first_cyc + 1);
      end
      checks++;
      if (hs_cyc[127] - hs_cyc[0] != 127) begin
        errors++; $display("FAIL nom_b2b: got span %0d want 127", hs_cyc[127] - hs_cyc[0]);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != hs_cyc[127] + 1) begin
        errors++; $display("FAIL nom_done_timing: got %0d pulses want 1 at %0d",
                           done_cyc.size(), hs_cyc[127] + 1);
      end
    end
    checks++;
    if (busy !== 1'b0 || overflow !== 1'b0 || short_chirp !== 1'b0) begin
      errors++; $display("FAIL nom_status: got %b%b%b want 000", busy, overflow, short_chirp);
    end
  endtask

  task automatic test_backpressure();
    bit ok; int bad, lbad;
    clear_mon(); rdy_mode = 1;
    arm_req(16'd32, 96'h1);
    grant();
    for (int k = 0; k < 120; k++) begin drive(k); tick(); end
    stop_dds();
    wait_done(400, ok);
    rdy_mode = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_done: got timeout want done"); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b want 1", overflow); end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d violations want 0", stab_err); end
    checks++;
    if (beats.size() !== 32) begin
      errors++; $display("FAIL bp_len: got %0d want 32", beats.size());
    end else begin
      bad = 0; lbad = 0;
      for (int i = 0; i < 32; i++) begin
        if (beats[i][31:16] !== 16'(beats[i][15:0] + 16'hB000)) bad++;
        if (i > 0 && beats[i][15:0] <= beats[i-1][15:0]) bad++;
        if (lasts[i] !== (i == 31)) lbad++;
      end
      checks++;
      if (beats[0] !== samp(0)) begin errors++; $display("FAIL bp_first: got %h want %h", beats[0], samp(0)); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL bp_order: got %0d bad beats want 0", bad); end
      checks++;
      if (lbad != 0) begin errors++; $display("FAIL bp_tlast: got %0d bad tlast want 0", lbad); end
    end
    checks++;
    if (short_chirp !== 1'b0) begin errors++; $display("FAIL bp_short: got %b want 0", short_chirp); end
  endtask

  task automatic test_early_end();
    bit ok; int bad, lbad, exp_n;
`ifdef WF_PACKER_PAD_EN
    exp_n = 64;
`else
    exp_n = 40;
`endif
    clear_mon(); rdy_mode = 0;
    arm_req(16'd64, 96'h2);
    grant();
    for (int k = 0; k < 40; k++) begin
      drive(k); chirp_done = (k == 39); tick();
    end
    stop_dds();
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL early_done: got timeout want done"); end
    checks++;
    if (short_chirp !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL early_flags: got short=%b ovf=%b want 1 0", short_chirp, overflow);
    end
    checks++;
    if (beats.size() != exp_n) begin
      errors++; $display("FAIL early_len: got %0d want %0d", beats.size(), exp_n);
    end else begin
      bad = 0; lbad = 0;
      for (int i = 0; i < exp_n; i++) begin
        if (beats[i] !== ((i < 40) ? samp(i) : 32'd0)) bad++;
        if (lasts[i] !== (i == exp_n - 1)) lbad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL early_data: got %0d bad beats want 0", bad); end
      checks++;
      if (lbad != 0) begin errors++; $display("FAIL early_tlast: got %0d bad tlast want 0", lbad); end
    end
  endtask

  task automatic test_req_handshake();
    bit ok; int bad;
    logic [95:0] up;
    up = 96'hFACE_0000_0000_0000_0000_0003;
    clear_mon(); rdy_mode = 0;
    arm_req(16'd8, up);
    last_params = {up, 32'd8};
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      drive(200 + k); tick();
      if (init_wf_write !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL req_hold: got %0d low cycles want 0", bad); end
    checks++;
    if (beats.size() != 0) begin errors++; $display("FAIL req_nobeats: got %0d want 0", beats.size()); end
    drive(250); grant();
    for (int k = 0; k < 8; k++) begin drive(300 + k); tick(); end
    stop_dds();
    wait_done(60, ok);
    checks++;
    if (!ok || beats.size() != 8) begin
      errors++; $display("FAIL req_len: got %0d beats done=%b want 8 1", beats.size(), ok);
    end else begin
      bad = 0;
      for (int i = 0; i < 8; i++) if (beats[i] !== samp(300 + i) || lasts[i] !== (i == 7)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL req_data: got %0d bad beats want 0", bad); end
    end
  endtask

  task automatic test_ignored_arms();
    bit ok;
    logic [95:0] up;
    up = 96'h5;
    clear_mon();
    arm_req(16'd0, 96'hBAD);
    checks++;
    if (busy !== 1'b0 || init_wf_write !== 1'b0) begin
      errors++; $display("FAIL ign_zero: got busy=%b init=%b want 0 0", busy, init_wf_write);
    end
    checks++;
    if (waveform_parameters !== last_params) begin
      errors++; $display("FAIL ign_zero_params: got %h want %h", waveform_parameters, last_params);
    end
    arm_req(16'd5, up);
    arm_req(16'd9, 96'hBAD);
    checks++;
    if (waveform_parameters !== {up, 32'd5} || init_wf_write !== 1'b1) begin
      errors++; $display("FAIL ign_busy: got %h init=%b want %h 1",
                         waveform_parameters, init_wf_write, {up, 32'd5});
    end
    grant();
    for (int k = 0; k < 5; k++) begin drive(k); tick(); end
    stop_dds();
    wait_done(60, ok);
    checks++;
    if (!ok || beats.size() != 5 || lasts[4] !== 1'b1) begin
      errors++; $display("FAIL ign_len: got %0d beats done=%b want 5 1", beats.size(), ok);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int bad;
    clear_mon(); rdy_mode = 0;
    arm_req(16'd128, 96'h7);
    grant();
    for (int k = 0; k < 128; k++) begin
      drive(k); tick();
      if (beats.size() >= 20) break;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (wfin_axis.tvalid !== 1'b0 || busy !== 1'b0 || init_wf_write !== 1'b0) begin
      errors++; $display("FAIL rst_async: got tvalid=%b busy=%b init=%b want 0 0 0",
                         wfin_axis.tvalid, busy, init_wf_write);
    end
    stop_dds();
    tick(2);
    reset = 1'b0;
    tick(3);
    checks++;
    if (wfin_axis.tvalid !== 1'b0 || waveform_parameters !== 128'd0) begin
      errors++; $display("FAIL rst_empty: got tvalid=%b params=%h want 0 0",
                         wfin_axis.tvalid, waveform_parameters);
    end
    clear_mon();
    arm_req(16'd4, 96'h8);
    grant();
    for (int k = 0; k < 4; k++) begin drive(500 + k); tick(); end
    stop_dds();
    wait_done(60, ok);
    checks++;
    if (!ok || beats.size() != 4) begin
      errors++; $display("FAIL rst_clean_len: got %0d beats done=%b want 4 1", beats.size(), ok);
    end else begin
      bad = 0;
      for (int i = 0; i < 4; i++) if (beats[i] !== samp(500 + i) || lasts[i] !== (i == 3)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rst_clean_data: got %0d bad beats want 0", bad); end
    end
  endtask

  initial begin
    last_params = '0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_end();
    test_req_handshake();
    test_ignored_arms();
    test_reset_mid();
    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
